round_robin_arbiter: RTL and testbench

// - Shares one resource among WIDTH requesters with round-robin fairness.
// - Output is a registered one-hot grant vector plus its binary index.
// - Drives a one-hot decoder/select fabric (index -> sel, grant_valid -> enable)
//   so that at most one requester owns the shared datapath at a time.
//

---
 rtl/round_robin_arbiter.sv | 134 +++++++++++++
 tb/tb_round_robin_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// Purpose: round-robin arbiter that hands one shared resource to one of WIDTH requesters at a time.
// Latency: a grant is registered one cycle after the request is seen. Every release is followed by one idle cycle.
// Backpressure: requests wait for as long as the resource is held. The holder is never pre-empted.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req[WIDTH]        level-sensitive request per requester
//   done              holder releases the resource (only looked at while granting)
//   grant[WIDTH]      registered one-hot grant, all-zero when idle
//   grant_idx         binary index of the holder, 0 when idle
//   grant_valid       high while a grant is held
//   timeout           one-cycle pulse after a forced release
// Optional feature: define ARB_TIMEOUT_EN to bound a grant to MAX_HOLD cycles.
// Without it, timeout is tied low and MAX_HOLD has no effect.
module round_robin_arbiter #(
    parameter int WIDTH     = 16,
    parameter int ADDR_SIZE = $clog2(WIDTH),
    parameter int MAX_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     req,
    input  logic                 done,
    output logic [WIDTH-1:0]     grant,
    output logic [ADDR_SIZE-1:0] grant_idx,
    output logic                 grant_valid,
    output logic                 timeout
);

    if (WIDTH < 2) begin : g_bad_width
        $error("round_robin_arbiter: WIDTH must be >= 2");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("round_robin_arbiter: MAX_HOLD must be >= 2");
    end

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]           state;
    logic [ADDR_SIZE-1:0] ptr;
    logic [ADDR_SIZE-1:0] pick_idx;
    logic [ADDR_SIZE-1:0] cand;
    logic [ADDR_SIZE-1:0] ptr_after;
    logic                 pick_vld;
    logic                 release_norm;
    logic                 release_any;

    // Modulo-WIDTH add. This works for any WIDTH, including values that are not a power of 2.
    function automatic logic [ADDR_SIZE-1:0] wrap_add(input logic [ADDR_SIZE-1:0] base,
                                                      input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= WIDTH) begin
            sum = sum - WIDTH;
        end
        return ADDR_SIZE'(sum);
    endfunction

    // The first requester at or after ptr, in circular order, wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cand = wrap_add(ptr, i);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // After a release, priority moves to the requester just past the old holder.
    assign ptr_after    = (grant_idx == ADDR_SIZE'(WIDTH - 1)) ? '0 : grant_idx + 1'b1;
    // A done that arrives together with a dropped request still counts as a single release.
    assign release_norm = done | ~req[grant_idx];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt;
    logic             hold_expired;

    assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign release_any  = release_norm | hold_expired;

    // hold_cnt stays at zero while idle, so every grant starts counting from 0.
    // A normal release in the expiry cycle wins, and no timeout is reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= (state == GRANT) && hold_expired && !release_norm;
            if (state == GRANT && !release_any) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign release_any = release_norm;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else if (state == IDLE) begin
            if (pick_vld) begin
                state       <= GRANT;
                grant       <= WIDTH'(1) << pick_idx;
                grant_idx   <= pick_idx;
                grant_valid <= 1'b1;
            end
        end else begin
            // Going back through IDLE forces one disabled cycle between owners.
            if (release_any) begin
                state       <= IDLE;
                grant       <= '0;
                grant_idx   <= '0;
                grant_valid <= 1'b0;
                ptr         <= ptr_after;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Purpose: directed, self-checking bench for round_robin_arbiter with WIDTH=16 and MAX_HOLD=8.
// Latency: the bench drives inputs 1 time unit after each rising edge and checks outputs at that same point.
// Backpressure: none. Every step is a fixed number of cycles, so the run always ends.
module tb_round_robin_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    int vectors     = 0;
    int miscompares = 0;

    round_robin_arbiter #(
        .WIDTH    (16),
        .MAX_HOLD (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'h0);
        chk({tag, ".valid"}, 32'(grant_valid), 32'h0);
        chk({tag, ".idx"}, 32'(grant_idx), 32'h0);
    endtask

    task automatic chk_held(input string tag, input int idx);
        logic [15:0] onehot;
        onehot = 16'h0001 << idx;
        chk({tag, ".grant"}, 32'(grant), 32'(onehot));
        chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
        chk({tag, ".valid"}, 32'(grant_valid), 32'h1);
    endtask

    initial begin
        reset = 1'b1;
        req   = 16'hFFFF;
        done  = 1'b0;

        // 1. Reset held for two edges while every requester is asking.
        step();
        chk_idle("rst0");
        chk("rst0.timeout", 32'(timeout), 32'h0);
        step();
        chk_idle("rst1");
        chk("rst1.timeout", 32'(timeout), 32'h0);
        reset = 1'b0;
        step();
        chk_held("rst_first", 0);

        // 2. Rotation between requesters 0 and 2.
        req  = 16'h0005;
        done = 1'b1;
        step();
        chk_idle("rot_gap0");
        done = 1'b0;
        step();
        chk_held("rot_g2a", 2);
        step();
        chk_held("rot_hold2", 2);
        done = 1'b1;
        step();
        chk_idle("rot_gap1");
        done = 1'b0;
        step();
        chk_held("rot_g0", 0);
        done = 1'b1;
        step();
        chk_idle("rot_gap2");
        done = 1'b0;
        step();
        chk_held("rot_g2b", 2);
        done = 1'b1;
        step();
        chk_idle("rot_gap3");
        done = 1'b0;

        // 3. Wrap: granting 14 moves ptr to 15. Then 15 is served before 1.
        req = 16'h4000;
        step();
        chk_held("wrap_g14", 14);
        req = 16'h8002;
        step();
        chk_idle("wrap_gap0");
        step();
        chk_held("wrap_g15", 15);
        done = 1'b1;
        step();
        chk_idle("wrap_gap1");
        done = 1'b0;
        step();
        chk_held("wrap_g1", 1);

        // 4. Dropping a request releases the grant. A non-requesting index is never picked.
        req = 16'h0010;
        step();
        chk_idle("drop_gap0");
        step();
        chk_held("drop_g4", 4);
        req = 16'h0000;
        step();
        chk_idle("drop_rel");
        step();
        chk_idle("drop_noreq");
        req = 16'h0101;
        step();
        chk_held("drop_g8", 8);
        done = 1'b1;
        req  = 16'h0000;
        step();
        chk_idle("dual_rel");
        done = 1'b0;
        step();
        chk_idle("dual_stay");
        chk("dual_stay.timeout", 32'(timeout), 32'h0);

        // 5. A holder that never lets go. ptr is 9, so requester 3 wins first.
        req = 16'h0028;
        for (int c = 0; c < 8; c++) begin
            step();
            chk_held($sformatf("hold_c%0d", c), 3);
            chk($sformatf("hold_c%0d.timeout", c), 32'(timeout), 32'h0);
        end
`ifdef ARB_TIMEOUT_EN
        step();
        chk_idle("to_gap");
        chk("to_pulse", 32'(timeout), 32'h1);
        step();
        chk_held("to_g5", 5);
        chk("to_pulse_end", 32'(timeout), 32'h0);
`else
        for (int c = 8; c < 58; c++) begin
            step();
            chk_held($sformatf("hold_c%0d", c), 3);
            chk($sformatf("hold_c%0d.timeout", c), 32'(timeout), 32'h0);
        end
`endif
        done = 1'b1;
        step();
        chk_idle("hold_rel");
        done = 1'b0;
        req  = 16'h0000;
        step();
        chk_idle("hold_quiet");

        // 6. Reset in the middle of a grant drops it at once and sends ptr back to 0.
        req = 16'h0080;
        step();
        chk_held("mid_g7", 7);
        reset = 1'b1;
        step();
        chk_idle("mid_rst");
        chk("mid_rst.timeout", 32'(timeout), 32'h0);
        reset = 1'b0;
        req   = 16'hFFFF;
        step();
        chk_held("mid_g0", 0);
        done = 1'b1;
        step();
        chk_idle("mid_gap");
        done = 1'b0;
        step();
        chk_held("mid_g1", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
